// File: rtl/conv_pe_scheduler.sv
// Sequences one 3x3x3 conv PE: weight bank load, then every filter per window, results into a credit FIFO.
// Latency: PE_LATENCY cycles from issue to FIFO capture; one filter per cycle when res_ready is held high.
// Backpressure: issue stalls while fifo_count+inflight reaches FIFO_DEPTH; SCHED_PERF_CNT_EN enables stall_cnt_o.
module conv_pe_scheduler #(
  parameter int NUM_OF_FILTERS = 16,
  parameter int PE_LATENCY     = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int DATA_W         = 216
) (
  input  logic                              clk_i,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic                              w_valid_i,
  output logic                              w_ready_o,
  input  logic [DATA_W-1:0]                 w_data_i,
  input  logic                              win_valid_i,
  output logic                              win_ready_o,
  input  logic [DATA_W-1:0]                 win_data_i,
  input  logic                              win_last_i,
  output logic [DATA_W-1:0]                 pe_in_a_o,
  output logic [DATA_W-1:0]                 pe_in_b_o,
  input  logic [63:0]                       pe_out_c_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [63:0]                       res_data_o,
  output logic [$clog2(NUM_OF_FILTERS)-1:0] res_filter_o,
  output logic                              res_last_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [31:0]                       stall_cnt_o
);

  localparam int FW = $clog2(NUM_OF_FILTERS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + PE_LATENCY + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [FW-1:0] LAST_F  = FW'(NUM_OF_FILTERS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_WAIT_WIN, S_ISSUE, S_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [FW-1:0]      widx, fidx;
  logic [DATA_W-1:0]  bank [NUM_OF_FILTERS];
  logic [DATA_W-1:0]  win_q;
  logic               win_last_q;
  logic               tag_vld_q  [PE_LATENCY];
  logic [FW-1:0]      tag_fidx_q [PE_LATENCY];
  logic               tag_last_q [PE_LATENCY];
  logic [CW-1:0]      inflight, fifo_count;
  logic               credit, issue, push, pop;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [63:0]        mem_dat  [FIFO_DEPTH];
  logic [FW-1:0]      mem_fid  [FIFO_DEPTH];
  logic               mem_last [FIFO_DEPTH];

  // Count of valid tags travelling through the PE shadow pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PE_LATENCY; i++) inflight = inflight + CW'(tag_vld_q[i]);
  end

  // Credit uses registered occupancy only; a pop in this cycle is not credited
  assign credit = (fifo_count + inflight) < DEPTH_C;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt   = state;
    w_ready_o   = 1'b0;
    win_ready_o = 1'b0;
    issue       = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state != S_IDLE);
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_LOAD_W;
      S_LOAD_W: begin
        w_ready_o = 1'b1;
        if (w_valid_i && widx == LAST_F) state_nxt = S_WAIT_WIN;
      end
      S_WAIT_WIN: begin
        win_ready_o = 1'b1;
        if (win_valid_i) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        issue = credit;
        if (credit && fidx == LAST_F) state_nxt = win_last_q ? S_DRAIN : S_WAIT_WIN;
      end
      S_DRAIN: begin
        if (inflight == '0 && fifo_count == '0) begin
          done_o    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign pe_in_a_o = issue ? win_q      : '0;
  assign pe_in_b_o = issue ? bank[fidx] : '0;

  // Weight/filter indices and latched window
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      widx       <= '0;
      fidx       <= '0;
      win_q      <= '0;
      win_last_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start_i) widx <= '0;
      if (state == S_LOAD_W && w_valid_i) widx <= widx + FW'(1);
      if (state == S_WAIT_WIN && win_valid_i) begin
        win_q      <= win_data_i;
        win_last_q <= win_last_i;
        fidx       <= '0;
      end
      if (issue) fidx <= fidx + FW'(1);
    end
  end

  // Weight bank holds its contents across reset
  always_ff @(posedge clk_i) begin
    if (state == S_LOAD_W && w_valid_i) bank[widx] <= w_data_i;
  end

  // Tag pipeline mirrors the PE latency so each result is labelled on exit
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int i = 0; i < PE_LATENCY; i++) begin
        tag_vld_q[i]  <= 1'b0;
        tag_fidx_q[i] <= '0;
        tag_last_q[i] <= 1'b0;
      end
    end else begin
      tag_vld_q[0]  <= issue;
      tag_fidx_q[0] <= fidx;
      tag_last_q[0] <= issue && win_last_q && (fidx == LAST_F);
      for (int i = 1; i < PE_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_fidx_q[i] <= tag_fidx_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  assign push = tag_vld_q[PE_LATENCY-1];
  assign pop  = res_valid_o && res_ready_i;

  // Result storage; occupancy is guarded by credit so no full check is needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_dat[wr_ptr]  <= pe_out_c_i;
      mem_fid[wr_ptr]  <= tag_fidx_q[PE_LATENCY-1];
      mem_last[wr_ptr] <= tag_last_q[PE_LATENCY-1];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign res_valid_o  = (fifo_count != '0);
  assign res_data_o   = res_valid_o ? mem_dat[rd_ptr]  : '0;
  assign res_filter_o = res_valid_o ? mem_fid[rd_ptr]  : '0;
  assign res_last_o   = res_valid_o ? mem_last[rd_ptr] : 1'b0;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of ISSUE cycles blocked by credit
  always_ff @(posedge clk_i) begin
    if (!rst_n)                                     stall_q <= '0;
    else if (state == S_IDLE && start_i)            stall_q <= '0;
    else if (state == S_ISSUE && !credit && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_conv_pe_scheduler.sv
// Directed bench for conv_pe_scheduler with a behavioural 2-stage dot-product PE.
// Results are captured by a pop monitor and compared against hand-derived sums 27*win_byte*k.
// Covers reset, basic frame, backpressure with push/pop at count 3, two windows with stray start, mid-frame reset.
module tb_conv_pe_scheduler;
  localparam int NF = 16;
  localparam int PE_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, w_valid_i, win_valid_i, win_last_i, res_ready_i;
  logic [215:0] w_data_i, win_data_i;
  logic         w_ready_o, win_ready_o, res_valid_o, res_last_o, busy_o, done_o;
  logic [215:0] pe_in_a_o, pe_in_b_o;
  logic [63:0]  pe_out_c_i, res_data_o;
  logic [3:0]   res_filter_o;
  logic [31:0]  stall_cnt_o;

  conv_pe_scheduler dut (
    .clk_i(clk), .rst_n(rst_n), .start_i(start_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .win_valid_i(win_valid_i), .win_ready_o(win_ready_o), .win_data_i(win_data_i),
    .win_last_i(win_last_i), .pe_in_a_o(pe_in_a_o), .pe_in_b_o(pe_in_b_o),
    .pe_out_c_i(pe_out_c_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_filter_o(res_filter_o), .res_last_o(res_last_o),
    .busy_o(busy_o), .done_o(done_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt, done_cyc, last_pop_cyc, issue_cnt, win_viol;
  logic [63:0] q_dat [$];
  logic [3:0]  q_fid [$];
  logic        q_last [$];
  logic [63:0] pe_pipe [PE_LAT];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dot(input logic [215:0] a, input logic [215:0] b);
    logic [63:0] s = '0;
    for (int i = 0; i < 27; i++) s += 64'(a[i*8 +: 8]) * 64'(b[i*8 +: 8]);
    return s;
  endfunction

  // Behavioural PE: result appears PE_LAT cycles after its inputs
  always @(posedge clk) begin
    pe_pipe[0] <= dot(pe_in_a_o, pe_in_b_o);
    for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign pe_out_c_i = pe_pipe[PE_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Observers sampled on the falling edge
  always @(negedge clk) begin
    if (res_valid_o && res_ready_i) begin
      q_dat.push_back(res_data_o);
      q_fid.push_back(res_filter_o);
      q_last.push_back(res_last_o);
      last_pop_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (pe_in_a_o != '0) begin
      issue_cnt++;
      if (win_ready_o) win_viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    q_dat.delete(); q_fid.delete(); q_last.delete();
    done_cnt = 0; done_cyc = 0; last_pop_cyc = 0; issue_cnt = 0; win_viol = 0;
  endtask

  task automatic load_bank();
    int t;
    logic [7:0] b;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < NF; k++) begin
      b = 8'(k);
      w_valid_i = 1'b1;
      w_data_i  = {27{b}};
      t = 0;
      while (!w_ready_o && t < 50) begin step(); t++; end
      if (t >= 50) chk("w_tmo", 1, 0);
      step();
    end
    w_valid_i = 1'b0;
  endtask

  task automatic send_win(input logic [7:0] v, input logic last);
    int t = 0;
    win_valid_i = 1'b1;
    win_data_i  = {27{v}};
    win_last_i  = last;
    while (!win_ready_o && t < 50) begin step(); t++; end
    if (t >= 50) chk("win_tmo", 1, 0);
    step();
    win_valid_i = 1'b0;
    win_last_i  = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int t = 0;
    while (done_cnt == 0 && t < bound) begin step(); t++; end
    chk("done_tmo", t >= bound, 0);
  endtask

  // Window w carries bytes w+1; filter k's weights are bytes k
  task automatic check_results(input int n);
    int sz;
    sz = q_dat.size();
    chk("n_res", sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      chk($sformatf("dat%0d", i), q_dat[i], 64'(27 * (i / NF + 1) * (i % NF)));
      chk($sformatf("fid%0d", i), q_fid[i], 64'(i % NF));
      chk($sformatf("last%0d", i), q_last[i], i == n - 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; w_valid_i = 1'b0; w_data_i = '0;
    win_valid_i = 1'b0; win_data_i = '0; win_last_i = 1'b0; res_ready_i = 1'b0;
    clear_obs();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_busy", busy_o, 0);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_win_ready", win_ready_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_pe_a", pe_in_a_o != '0, 0);
    chk("rst_stall", stall_cnt_o, 0);

    // Basic frame
    clear_obs();
    res_ready_i = 1'b1;
    load_bank();
    send_win(8'd1, 1'b1);
    wait_done(200);
    check_results(16);
    step();
    chk("b_done_cnt", done_cnt, 1);
    chk("b_done_after_pop", done_cyc > last_pop_cyc, 1);
    chk("b_busy_end", busy_o, 0);

    // Backpressure, then a push and pop together with three entries held
    clear_obs();
    res_ready_i = 1'b0;
    load_bank();
    send_win(8'd1, 1'b1);
    repeat (10) step();
    chk("bp_issues4", issue_cnt, 4);
    chk("bp_valid", res_valid_o, 1);
    chk("bp_head_fid", res_filter_o, 0);
`ifdef SCHED_PERF_CNT_EN
    chk("bp_stall_nz", stall_cnt_o != 0, 1);
`else
    chk("bp_stall_zero", stall_cnt_o, 0);
`endif
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    step();
    step();
    res_ready_i = 1'b1;
    chk("pp_head_fid", res_filter_o, 1);
    step();
    res_ready_i = 1'b0;
    repeat (8) step();
    chk("pp_issues6", issue_cnt, 6);
    chk("pp_head_fid2", res_filter_o, 2);
    res_ready_i = 1'b1;
    wait_done(300);
    check_results(16);
    chk("bp_done_cnt", done_cnt, 1);

    // Two windows with a stray start during ISSUE
    clear_obs();
    load_bank();
    send_win(8'd1, 1'b0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("tw_busy", busy_o, 1);
    send_win(8'd2, 1'b1);
    wait_done(300);
    check_results(32);
    chk("tw_win_ready_issue", win_viol, 0);
    step();
    chk("tw_done_cnt", done_cnt, 1);

    // Reset in the middle of ISSUE
    clear_obs();
    res_ready_i = 1'b0;
    load_bank();
    send_win(8'd1, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("mr_busy", busy_o, 0);
    chk("mr_res_valid", res_valid_o, 0);
    chk("mr_pe_b", pe_in_b_o != '0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mr_w_ready", w_ready_o, 0);
    chk("mr_stall", stall_cnt_o, 0);
    res_ready_i = 1'b1;
    repeat (20) step();
    chk("mr_no_results", q_dat.size(), 0);
    chk("mr_no_done", done_cnt, 0);
    chk("mr_res_valid_end", res_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
